// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: stall FSM states and control-word constants.
package pipe_pkg;
  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_e;
  localparam int CTRL_W = 8;
  localparam logic [CTRL_W-1:0] BUBBLE = 8'h00;
  localparam int DEF_REG_AW = 3;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX hazard inputs and front-end control outputs of the stall unit.
interface hazard_stall_unit_if #(
    parameter int REG_AW = pipe_pkg::DEF_REG_AW,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_busy;
    logic              branch_taken;
    logic              st;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
               mem_busy, branch_taken,
        input  st, pc_we, ifid_we, ifid_flush, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
               mem_busy, branch_taken,
        output st, pc_we, ifid_we, ifid_flush, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by perf counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + CNT_W'(1);
    end
endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch hazard control: drives the bubble select and front-end
// write enables, holding the front end for LOAD_STALL cycles per load-use.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int LOAD_STALL  = 2,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_stall_unit_if.slave  bus
);
    localparam logic [0:0] S_RUN  = RUN;
    localparam logic [0:0] S_HOLD = HOLD;

    logic [0:0] state, state_d;
    logic [3:0] rem, rem_d;
    logic       hz;
    logic       st, pc_we, ifid_we, ifid_flush;

    always_comb begin
        hz = bus.ex_mem_read &
             ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) |
              (bus.id_use_rt & (bus.id_rt == bus.ex_rd))) &
             !((ZERO_REG_EN != 0) && (bus.ex_rd == '0));
    end

    // Priority: reset > branch > HOLD > hazard > normal flow.
    always_comb begin
        st         = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        state_d    = state;
        rem_d      = rem;
        if (!rst_n) begin
            st      = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            state_d = S_RUN;
            rem_d   = '0;
        end else if (bus.branch_taken) begin
            // Wrong-path ID instruction: its hazard is irrelevant.
            st         = 1'b1;
            ifid_flush = 1'b1;
            ifid_we    = 1'b0;
            state_d    = S_RUN;
            rem_d      = '0;
        end else if (state == S_HOLD) begin
            st      = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            if (!bus.mem_busy) begin
                if (rem == 4'd1) begin
                    state_d = S_RUN;
                    rem_d   = '0;
                end else begin
                    rem_d = rem - 4'd1;
                end
            end
        end else if (hz) begin
            st      = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            if (LOAD_STALL > 1) begin
                state_d = S_HOLD;
                rem_d   = 4'(LOAD_STALL - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        state <= state_d;
        rem   <= rem_d;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (st & rst_n),
        .q   (bus.stall_count)
    );

    assign bus.st         = st;
    assign bus.pc_we      = pc_we;
    assign bus.ifid_we    = ifid_we;
    assign bus.ifid_flush = ifid_flush;
endmodule
